// File: rtl/stb_gen_pkg.sv
// Shared types and helpers for the period-measuring strobe generator.
// The window compare is done at 64 bits, so instantiating modules need CNT_W <= 64.
package stb_gen_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEAS,
        GEN
    } stb_state_e;

    localparam int unsigned MIN_PERIOD = 2;

    // Strobe window: phase in [phase_start, phase_start + width), never wraps
    function automatic logic in_window(input logic [63:0] phase,
                                       input logic [63:0] phase_start,
                                       input logic [63:0] width);
        return (phase >= phase_start) && ((phase - phase_start) < width);
    endfunction

endpackage

// File: rtl/period_stb_gen_if.sv
// Measurement request/status bus of period_stb_gen.
// The master pulses meas_req and watches busy, err and the period readout.
interface period_stb_gen_if #(
    parameter int unsigned CNT_W = 32
);
    logic             meas_req;
    logic             busy;
    logic [CNT_W-1:0] period;
    logic             period_vld;
    logic             err;

    modport master (
        output meas_req,
        input  busy,
        input  period,
        input  period_vld,
        input  err
    );

    modport slave (
        input  meas_req,
        output busy,
        output period,
        output period_vld,
        output err
    );
endinterface

// File: rtl/sig_edge_sync.sv
// Multi-stage synchroniser followed by a registered rising-edge pulse.
// The pulse appears SYNC_STAGES+1 cycles after the input transition.
module sig_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic arst_i,
    input  logic sig_i,
    output logic edge_o
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_edge;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_edge <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sig_i};
            r_prev <= r_sync[SYNC_STAGES-1];
            r_edge <= r_sync[SYNC_STAGES-1] & ~r_prev;
        end
    end

    assign edge_o = r_edge;
endmodule

// File: rtl/period_stb_gen.sv
// Measures the averaged period of sig_i, then emits a strobe phase-locked to the
// final measured edge with programmable phase offset and width.
module period_stb_gen
    import stb_gen_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned AVG_LOG2    = 2,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              sig_i,
    input  logic              oe_i,
    input  logic [CNT_W-1:0]  phase_i,
    input  logic [CNT_W-1:0]  width_i,
    input  logic [CNT_W-1:0]  timeout_i,
    output logic              stb_o,
    period_stb_gen_if.slave   bus
);
    localparam int unsigned      SUM_W    = CNT_W + AVG_LOG2;
    localparam int unsigned      IDX_W    = AVG_LOG2 + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'((1 << AVG_LOG2) - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    stb_state_e       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_t_cnt, w_t_cnt_nxt;
    logic [CNT_W-1:0] r_phase, w_phase_nxt;
    logic [CNT_W-1:0] r_period, w_period_nxt;
    logic [SUM_W-1:0] r_acc, w_acc_nxt, w_sum;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic             r_err, w_err_nxt;
    logic             r_stb, w_stb_nxt;
    logic [CNT_W-1:0] w_avg, w_win_phase;
    logic             w_edge, w_accept, w_fault, w_win_en;

    sig_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .sig_i  (sig_i),
        .edge_o (w_edge)
    );

    assign w_accept = bus.meas_req && ((r_state == IDLE) || (r_state == GEN));
    assign w_sum    = r_acc + SUM_W'(r_t_cnt);
    assign w_avg    = CNT_W'(w_sum >> AVG_LOG2);

    // A request restarts the interval count so ARM can time out from it
    always_comb begin
        if (w_edge || w_accept) begin
            w_t_cnt_nxt = CNT_ONE;
        end else if (r_t_cnt == CNT_MAX) begin
            w_t_cnt_nxt = r_t_cnt;
        end else begin
            w_t_cnt_nxt = r_t_cnt + CNT_ONE;
        end
    end

    assign w_fault = !w_edge && (((timeout_i != '0) && (w_t_cnt_nxt >= timeout_i)) ||
                                 (r_t_cnt == CNT_MAX));

    always_comb begin
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_idx_nxt    = r_idx;
        w_period_nxt = r_period;
        w_err_nxt    = r_err;
        w_phase_nxt  = '0;
        w_win_en     = 1'b0;
        w_win_phase  = '0;
        unique case (r_state)
            IDLE: begin
                if (bus.meas_req) begin
                    w_state_nxt = ARM;
                    w_err_nxt   = 1'b0;
                    w_acc_nxt   = '0;
                    w_idx_nxt   = '0;
                end
            end
            ARM: begin
                if (w_edge) begin
                    w_state_nxt = MEAS;
                end else if (w_fault) begin
                    w_state_nxt = IDLE;
                    w_err_nxt   = 1'b1;
                end
            end
            MEAS: begin
                if (w_edge) begin
                    w_acc_nxt = w_sum;
                    w_idx_nxt = r_idx + IDX_ONE;
                    if (r_idx == LAST_IDX) begin
                        if (w_avg < CNT_W'(MIN_PERIOD)) begin
                            w_state_nxt = IDLE;
                            w_err_nxt   = 1'b1;
                        end else begin
                            // This edge cycle is phase 0 of the generated period
                            w_state_nxt  = GEN;
                            w_period_nxt = w_avg;
                            w_phase_nxt  = CNT_ONE;
                            w_win_en     = 1'b1;
                        end
                    end
                end else if (w_fault) begin
                    w_state_nxt = IDLE;
                    w_err_nxt   = 1'b1;
                end
            end
            GEN: begin
                if (bus.meas_req) begin
                    w_state_nxt = ARM;
                    w_err_nxt   = 1'b0;
                    w_acc_nxt   = '0;
                    w_idx_nxt   = '0;
                end else begin
                    w_phase_nxt = (r_phase >= r_period - CNT_ONE) ? '0 : r_phase + CNT_ONE;
                    w_win_en    = 1'b1;
                    w_win_phase = r_phase;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        w_stb_nxt = w_win_en && oe_i &&
                    in_window(64'(w_win_phase), 64'(phase_i), 64'(width_i));
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state  <= IDLE;
            r_t_cnt  <= '0;
            r_phase  <= '0;
            r_period <= '0;
            r_acc    <= '0;
            r_idx    <= '0;
            r_err    <= 1'b0;
            r_stb    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_t_cnt  <= w_t_cnt_nxt;
            r_phase  <= w_phase_nxt;
            r_period <= w_period_nxt;
            r_acc    <= w_acc_nxt;
            r_idx    <= w_idx_nxt;
            r_err    <= w_err_nxt;
            r_stb    <= w_stb_nxt;
        end
    end

    assign stb_o          = r_stb;
    assign bus.busy       = (r_state == ARM) || (r_state == MEAS);
    assign bus.period_vld = (r_state == GEN);
    assign bus.period     = r_period;
    assign bus.err        = r_err;
endmodule
